// File: rtl/multdiv_pkg.sv
// Shared constants and state encoding for the multdiv unit's sequential datapaths.
// Imported by the Booth multiplier and its recoder.
package multdiv_pkg;

   localparam int MULT_WIDTH = 32;
   localparam int MULT_STEPS = MULT_WIDTH / 2;
   localparam int MULT_CNT_W = 5;

   // Booth recode window inside the partial-product register
   localparam int REC_LSB = 0;
   localparam int REC_MSB = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mult_state_e;

endpackage

// File: rtl/mult_ctrl.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window to nothing / +-M / +-2M.
// Purely combinational.
module mult_ctrl
   import multdiv_pkg::*;
(
   output logic       do_nothing,
   output logic       sub,
   output logic       sl,
   input  logic [2:0] lsb
);

   always_comb begin
      do_nothing = (lsb == 3'b000) || (lsb == 3'b111);
      sub        = lsb[2] && !do_nothing;
      sl         = (lsb == 3'b011) || (lsb == 3'b100);
   end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed multiplier, radix-4 Booth, one recode step per clock.
// Returns the low WIDTH product bits and a signed-overflow flag.
module booth_mult_seq
   import multdiv_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH,
   parameter int STEPS = WIDTH / 2,
   parameter int CNT_W = MULT_CNT_W
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             ctrl_MULT,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   // Two guard bits on the accumulator keep +-2M exact even for M = -2^(WIDTH-1).
   localparam int ACC_W = WIDTH + 2;
   localparam int P_W   = ACC_W + WIDTH + 1;

   // Handshake: ctrl_MULT is a start pulse sampled every edge in any state (a
   // start while BUSY restarts, a start in DONE chains); data_resultRDY is a
   // one-cycle strobe and data_result/data_exception hold until the next one.

   mult_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] m_q, m_d;
   logic [P_W-1:0]   p_q, p_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             exception_q, exception_d;
   logic             rdy_q, rdy_d;
   logic             busy_q, busy_d;

   logic             rec_nop;
   logic             rec_sub;
   logic             rec_sl;

   logic [ACC_W-1:0]   m_sel;
   logic [ACC_W-1:0]   addend;
   logic [ACC_W-1:0]   acc_sum;
   logic [P_W-1:0]     p_step;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH:0]     prod_hi;
   logic               prod_ovf;
   logic               last_step;

   mult_ctrl u_rec (
      .do_nothing (rec_nop),
      .sub        (rec_sub),
      .sl         (rec_sl),
      .lsb        (p_q[REC_MSB:REC_LSB])
   );

   always_comb begin
      m_sel = rec_sl ? {m_q[ACC_W-2:0], 1'b0} : m_q;
      if (rec_nop) begin
         addend = '0;
      end else if (rec_sub) begin
         addend = (~m_sel) + ACC_W'(1);
      end else begin
         addend = m_sel;
      end

      acc_sum = p_q[P_W-1 -: ACC_W] + addend;
      // Add into the upper field, then arithmetic shift right by two.
      p_step  = {{2{acc_sum[ACC_W-1]}}, acc_sum, p_q[WIDTH:2]};

      product  = p_step[2*WIDTH:1];
      prod_hi  = product[2*WIDTH-1:WIDTH-1];
      prod_ovf = !((prod_hi == '0) || (&prod_hi));

      last_step = (cnt_q == CNT_W'(STEPS - 1));
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      m_d         = m_q;
      p_d         = p_q;
      result_d    = result_q;
      exception_d = exception_q;

      if (ctrl_MULT) begin
         state_d = BUSY;
         cnt_d   = '0;
         m_d     = {{2{data_operandA[WIDTH-1]}}, data_operandA};
         p_d     = {{ACC_W{1'b0}}, data_operandB, 1'b0};
      end else begin
         case (state_q)
            BUSY: begin
               p_d   = p_step;
               cnt_d = cnt_q + CNT_W'(1);
               if (last_step) begin
                  state_d     = DONE;
                  cnt_d       = '0;
                  result_d    = product[WIDTH-1:0];
                  exception_d = prod_ovf;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end

      busy_d = (state_d == BUSY);
      rdy_d  = (state_d == DONE);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         m_q         <= '0;
         p_q         <= '0;
         result_q    <= '0;
         exception_q <= 1'b0;
         rdy_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         m_q         <= m_d;
         p_q         <= p_d;
         result_q    <= result_d;
         exception_q <= exception_d;
         rdy_q       <= rdy_d;
         busy_q      <= busy_d;
      end
   end

   assign data_result    = result_q;
   assign data_exception = exception_q;
   assign data_resultRDY = rdy_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed table, corner sequences,
// and random operands against a plain-arithmetic reference multiply.
module tb_booth_mult_seq;

   logic        clock;
   logic        reset_n;
   logic        ctrl_MULT;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   int          n_vec;
   int          n_fail;
   logic [32:0] exp_q[$];

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        e;
   } vec_t;

   vec_t vecs[11];

   booth_mult_seq dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .ctrl_MULT      (ctrl_MULT),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      longint      p;
      logic [63:0] pv;
      p  = longint'($signed(a)) * longint'($signed(b));
      pv = p;
      return {!((pv[63:31] == '0) || (pv[63:31] == '1)), pv[31:0]};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Caller sits at a negedge; the start is sampled on the next posedge.
   task automatic pulse(input logic [31:0] a, input logic [31:0] b);
      ctrl_MULT     = 1'b1;
      data_operandA = a;
      data_operandB = b;
      @(negedge clock);
      ctrl_MULT = 1'b0;
   endtask

   // Watches 21 samples starting just after the start edge; scribbles operands.
   task automatic observe(output int lat, output int rdy_n, output int busy_n,
                          output logic [31:0] r, output logic e);
      logic [32:0] exp;
      lat = 0; rdy_n = 0; busy_n = 0; r = '0; e = 1'b0;
      for (int i = 0; i <= 20; i++) begin
         if (i > 0) @(negedge clock);
         data_operandA = $urandom;
         data_operandB = $urandom;
         if (busy === 1'b1) busy_n++;
         if (data_resultRDY === 1'b1) begin
            rdy_n++;
            if (lat == 0) begin
               lat = i; r = data_result; e = data_exception;
            end
            if (exp_q.size() == 0) begin
               n_vec++; n_fail++;
               $display("FAIL unexpected_rdy: got RDY at sample %0d required none", i);
            end else begin
               exp = exp_q.pop_front();
               chk("scoreboard", {31'b0, data_exception, data_result}, {31'b0, exp});
            end
         end
      end
   endtask

   task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ee);
      int          lat, rdy_n, busy_n;
      logic [31:0] r;
      logic        e;
      exp_q.push_back(ref_mul(a, b));
      pulse(a, b);
      observe(lat, rdy_n, busy_n, r, e);
      chk({nm, "_latency"}, lat, 16);
      chk({nm, "_rdy_count"}, rdy_n, 1);
      chk({nm, "_busy_cycles"}, busy_n, 16);
      chk({nm, "_result"}, r, er);
      chk({nm, "_exception"}, e, ee);
   endtask

   initial begin
      int          lat, rdy_n, busy_n, cnt;
      logic [31:0] r, a, b;
      logic        e;
      logic [32:0] m;
      logic [32:0] exp;
      logic [31:0] extremes[5];

      n_vec = 0;
      n_fail = 0;
      extremes[0] = 32'h8000_0000; extremes[1] = 32'h7FFF_FFFF;
      extremes[2] = 32'hFFFF_FFFF; extremes[3] = 32'h0000_0000;
      extremes[4] = 32'h0000_0001;

      vecs[0]  = '{"mul_6x7",        32'd6,          32'd7,          32'h0000_002A, 1'b0};
      vecs[1]  = '{"mul_m3x5",       32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFF1, 1'b0};
      vecs[2]  = '{"mul_min_x1",     32'h8000_0000, 32'd1,          32'h8000_0000, 1'b0};
      vecs[3]  = '{"mul_max_x2",     32'h7FFF_FFFF, 32'd2,          32'hFFFF_FFFE, 1'b1};
      vecs[4]  = '{"mul_2p16_sq",    32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
      vecs[5]  = '{"mul_min_xm1",    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
      vecs[6]  = '{"mul_min_sq",     32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
      vecs[7]  = '{"mul_zero",       32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 1'b0};
      vecs[8]  = '{"mul_m1_sq",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
      vecs[9]  = '{"mul_max_sq",     32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1};
      vecs[10] = '{"mul_m1_x_min",   32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b1};

      reset_n = 1'b0;
      ctrl_MULT = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      repeat (3) @(negedge clock);
      chk("reset_result", data_result, 0);
      chk("reset_exception", data_exception, 0);
      chk("reset_rdy", data_resultRDY, 0);
      chk("reset_busy", busy, 0);
      reset_n = 1'b1;
      @(negedge clock);

      foreach (vecs[i]) do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].e);

      // Restart while busy: only the second operation completes.
      pulse(32'd100, 32'd100);
      cnt = 0;
      repeat (7) begin
         @(negedge clock);
         if (data_resultRDY === 1'b1) cnt++;
      end
      exp_q.push_back(ref_mul(32'd3, 32'd4));
      pulse(32'd3, 32'd4);
      observe(lat, rdy_n, busy_n, r, e);
      chk("abort_rdy_before_restart", cnt, 0);
      chk("abort_latency", lat, 16);
      chk("abort_rdy_count", rdy_n, 1);
      chk("abort_result", r, 32'h0000_000C);

      // Start during DONE: old result strobes, new one follows 16 cycles later.
      exp_q.push_back(ref_mul(32'd6, 32'd7));
      pulse(32'd6, 32'd7);
      repeat (16) @(negedge clock);
      chk("done_start_rdy", data_resultRDY, 1);
      chk("done_start_old_result", data_result, 32'h0000_002A);
      if (data_resultRDY === 1'b1 && exp_q.size() != 0) begin
         exp = exp_q.pop_front();
         chk("done_start_scoreboard", {31'b0, data_exception, data_result}, {31'b0, exp});
      end
      exp_q.push_back(ref_mul(32'd5, 32'd5));
      pulse(32'd5, 32'd5);
      observe(lat, rdy_n, busy_n, r, e);
      chk("done_start_latency", lat, 16);
      chk("done_start_busy_cycles", busy_n, 16);
      chk("done_start_new_result", r, 32'h0000_0019);

      // Reset at step 10 aborts silently and clears the outputs.
      pulse(32'd1234, 32'd5678);
      repeat (9) @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      chk("midreset_busy", busy, 0);
      chk("midreset_rdy", data_resultRDY, 0);
      chk("midreset_result", data_result, 0);
      chk("midreset_exception", data_exception, 0);
      observe(lat, rdy_n, busy_n, r, e);
      chk("midreset_no_rdy", rdy_n, 0);
      chk("midreset_idle", busy_n, 0);
      do_op("after_reset_9x9", 32'd9, 32'd9, 32'h0000_0051, 1'b0);

      // Start held high restarts every cycle and never completes.
      ctrl_MULT = 1'b1;
      data_operandA = 32'hFFFF_FF00;
      data_operandB = 32'h0000_0300;
      cnt = 0;
      busy_n = 0;
      repeat (40) begin
         @(negedge clock);
         if (data_resultRDY === 1'b1) cnt++;
         if (busy === 1'b1) busy_n++;
      end
      ctrl_MULT = 1'b0;
      chk("held_start_no_rdy", cnt, 0);
      chk("held_start_busy", busy_n, 40);
      exp_q.push_back(ref_mul(32'hFFFF_FF00, 32'h0000_0300));
      observe(lat, rdy_n, busy_n, r, e);
      chk("held_release_latency", lat, 16);
      chk("held_release_result", r, 32'hFFFD_0000);

      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 3))
            0: begin a = $urandom; b = $urandom; end
            1: begin
               a = 32'($signed($urandom_range(0, 200)) - 100);
               b = 32'($signed($urandom_range(0, 200)) - 100);
            end
            2: begin
               a = extremes[$urandom_range(0, 4)];
               b = extremes[$urandom_range(0, 4)];
            end
            default: begin
               a = 32'd1 << $urandom_range(0, 31);
               b = $urandom;
            end
         endcase
         m = ref_mul(a, b);
         do_op($sformatf("rand%0d", i), a, b, m[31:0], m[32]);
      end

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Sequential signed 32x32 multiplier using radix-4 (modified) Booth recoding, one recode step per clock, 16 steps per product.
- Datapath and controller stage directly downstream of the combinational recoder `mult_ctrl`.
- Consumes the recoder's do_nothing/sub/sl outputs each cycle.
- Produces the low 32 product bits plus a signed-overflow flag for the processor's multdiv unit.

Parameters:
- WIDTH, 32, operand and result width; must be even.
- STEPS, WIDTH/2 (16), Booth iterations per product.
- CNT_W, 5, width of the step counter; must hold STEPS.

Ports:
- clock  in  1  rising-edge clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- ctrl_MULT  in  1  start pulse, sampled on the rising edge of clock.
- data_operandA  in  WIDTH  multiplicand, two's complement.
- data_operandB  in  WIDTH  multiplier, two's complement.
- data_result  out  WIDTH  low WIDTH bits of the product.
- data_exception  out  1  high when the product does not fit in signed WIDTH bits.
- data_resultRDY  out  1  one-cycle completion strobe.
- busy  out  1  high while an operation is in progress.

Behaviour:
Reset:
- reset_n low at a rising edge forces IDLE, counter 0, product register 0.
- All outputs become 0.
- Reset overrides any start or step in the same cycle, including mid-operation. No result is produced for the aborted operation.

State machine:
- States: IDLE, BUSY, DONE.
- IDLE: on ctrl_MULT=1, latch M=operandA into a WIDTH+2 register, sign-extended.
- IDLE load: set P={ (WIDTH+2)'b0, operandB, 1'b0 }, counter=0, go to BUSY.
- BUSY: each edge performs one step and increments the counter. After step STEPS (counter==STEPS-1), register the result and go to DONE.
- DONE: lasts exactly one cycle with data_resultRDY=1, then returns to IDLE.

Booth step:
- Apply `mult_ctrl` to P[2:0].
- Addend = sl ? (M<<1) : M. Negate it when sub=1 (two's complement at WIDTH+2 bits). Use zero when do_nothing=1.
- Add the addend to P's upper WIDTH+2 bits.
- Shift the whole P arithmetically right by 2, replicating the sign bit.
- Recode table (P[2:0] -> action):
  - 000, 111: nothing.
  - 001, 010: +M.
  - 011: +2M.
  - 100: -2M.
  - 101, 110: -M.
- The accumulator is WIDTH+2 bits so that ±2M with M=-2^(WIDTH-1) never overflows.

Result:
- Full product = P bits [2WIDTH:1].
- data_result = product[WIDTH-1:0].
- data_exception = 1 unless product[2WIDTH-1:WIDTH-1] is all zeros or all ones.

Latency and output timing:
- Start sampled at edge N. Steps occur at edges N+1..N+16. data_resultRDY is high between edges N+16 and N+17.
- data_result and data_exception update only at the DONE transition.
- data_result and data_exception then hold until the next completed operation. They are not cleared by start.
- busy = 1 in BUSY, 0 in IDLE and DONE.

Boundary cases:
- ctrl_MULT during BUSY: abort the current operation, reload with the new operands, counter=0. No RDY is produced for the aborted operation.
- ctrl_MULT during DONE: RDY is still asserted this cycle with the old result. The new operands load and the next state is BUSY.
- Operands change while BUSY: ignored, because they are latched.
- ctrl_MULT held high: restarts every cycle, so RDY never asserts. This is the required behaviour.
- Zero operand: still takes the full 16 steps; no early termination.

Decomposition:
- Shared package `multdiv_pkg`:
  - State encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
  - WIDTH/STEPS constants.
  - Recode bit positions.
- One sub-module: instantiate the existing `mult_ctrl` (port order do_nothing, sub, sl, lsb) for recoding.
- The adder/shift datapath and FSM stay inline.

Test Plan:
- 6 x 7, start pulse at edge N -> RDY high only during cycle N+16..N+17; result 0x0000002A, exception 0, busy high for 16 cycles.
- -3 x 5 (0xFFFFFFFD, 0x00000005) -> result 0xFFFFFFF1, exception 0. Also 0x80000000 x 0x00000001 -> result 0x80000000, exception 0.
- 0x7FFFFFFF x 2 -> result 0xFFFFFFFE, exception 1. 0x00010000 x 0x00010000 -> result 0x00000000, exception 1.
- 0x80000000 x 0xFFFFFFFF -> result 0x80000000, exception 1. 0x80000000 x 0x80000000 -> result 0, exception 1 (exercises -2M at the most negative M).
- Start 100 x 100, re-pulse ctrl_MULT with 3 x 4 eight cycles later -> single RDY 16 cycles after the second pulse, result 0x0000000C. Also start during DONE -> RDY that cycle shows the old result, then a new RDY 16 cycles later.
- reset_n low for one edge at step 10 -> busy 0, outputs 0, no RDY. A following 9 x 9 start completes normally with result 0x00000051.
